// File: rtl/serial_link_pkg.sv
// ---------------------------------------------------------------------------
// serial_link_pkg
// Shared definitions for the clk_32f serial transmit path.
//   SYM_W     : symbol width in bits
//   IDLE_SYM  : training / idle comma
//   FILL_SYM  : fill symbol sent in ACTIVE when no requester has data
//   link_state_e : scheduler link state (TRAIN / ACTIVE)
// ---------------------------------------------------------------------------
package serial_link_pkg;

    localparam int SYM_W = 8;

    localparam logic [SYM_W-1:0] IDLE_SYM = 8'hBC;
    localparam logic [SYM_W-1:0] FILL_SYM = 8'h7C;

    typedef enum logic {
        ST_TRAIN  = 1'b0,
        ST_ACTIVE = 1'b1
    } link_state_e;

endpackage

// File: rtl/tx_byte_shifter.sv
// ---------------------------------------------------------------------------
// tx_byte_shifter
// Owns the bit counter and the output shift register. A symbol presented on
// sym_i is latched on the edge that ends a boundary cycle (cnt == 0) and is
// then sent MSB-first, one bit per clk_32f edge.
// Ports:
//   clk_32f      in   bit clock
//   reset        in   synchronous, active-low
//   sym_i        in   symbol to latch at the next boundary edge
//   boundary_o   out  1 while cnt == 0 (symbol selection cycle)
//   serial_out_o out  registered serial bit
//   sym_start_o  out  registered; 1 while serial_out_o carries bit 7
// ---------------------------------------------------------------------------
module tx_byte_shifter
    import serial_link_pkg::*;
(
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [SYM_W-1:0] sym_i,
    output logic             boundary_o,
    output logic             serial_out_o,
    output logic             sym_start_o
);

    localparam int CNT_W = $clog2(SYM_W);

    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [SYM_W-1:0] shift_q,  shift_d;
    logic             serial_q, serial_d;
    logic             start_q,  start_d;

    assign boundary_o   = (cnt_q == '0);
    assign serial_out_o = serial_q;
    assign sym_start_o  = start_q;

    always_comb begin
        // Counter free-runs and wraps naturally at SYM_W (a power of two).
        cnt_d = cnt_q + 1'b1;
        if (boundary_o) begin
            // Bit 7 goes straight to the output; the remaining bits are
            // left-justified so the next edge picks up bit 6.
            serial_d = sym_i[SYM_W-1];
            shift_d  = {sym_i[SYM_W-2:0], 1'b0};
            start_d  = 1'b1;
        end else begin
            serial_d = shift_q[SYM_W-1];
            shift_d  = {shift_q[SYM_W-2:0], 1'b0};
            start_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            cnt_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            start_q  <= start_d;
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// ---------------------------------------------------------------------------
// serial_tx_scheduler
// Byte scheduler for the clk_32f serial transmit path. Trains the link with
// IDLE_SYM commas, then round-robin arbitrates two valid/ready requesters,
// inserting FILL_SYM when neither has data. Serialization is delegated to
// tx_byte_shifter.
// Optional feature macro: TX_STATS_EN adds per-lane 16-bit handshake
// counters byte_cnt0 / byte_cnt1.
// Ports:
//   clk_32f            in   bit clock
//   reset              in   synchronous, active-low
//   link_en            in   permit leaving TRAIN; sampled at boundaries only
//   valid0/data0       in   requester 0 request and byte
//   ready0             out  combinational; byte 0 accepted this cycle
//   valid1/data1       in   requester 1 request and byte
//   ready1             out  combinational; byte 1 accepted this cycle
//   serial_out         out  registered serial bit (MSB first)
//   active             out  registered; 1 while in ACTIVE
//   sym_start          out  registered; 1 while serial_out carries bit 7
//   byte_cnt0/1        out  (TX_STATS_EN only) wrapping handshake counts
// ---------------------------------------------------------------------------
module serial_tx_scheduler #(
    parameter int          TRAIN_COMMAS = 4,
    parameter logic [7:0]  IDLE_SYM     = serial_link_pkg::IDLE_SYM,
    parameter logic [7:0]  FILL_SYM     = serial_link_pkg::FILL_SYM
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        link_en,
    input  logic        valid0,
    input  logic [7:0]  data0,
    output logic        ready0,
    input  logic        valid1,
    input  logic [7:0]  data1,
    output logic        ready1,
    output logic        serial_out,
    output logic        active,
    output logic        sym_start
`ifdef TX_STATS_EN
    ,
    output logic [15:0] byte_cnt0,
    output logic [15:0] byte_cnt1
`endif
);

    import serial_link_pkg::*;

    localparam logic [3:0] COMMA_TGT = 4'(TRAIN_COMMAS);

    link_state_e state_q, state_d;
    logic [3:0]  comma_q, comma_d;
    logic [3:0]  comma_inc;
    logic        last_q,  last_d;     // 1: lane 1 was granted last
    logic        sel0, sel1;
    logic        grant0, grant1;
    logic        boundary;
    logic [7:0]  sym;

    tx_byte_shifter u_shifter (
        .clk_32f      (clk_32f),
        .reset        (reset),
        .sym_i        (sym),
        .boundary_o   (boundary),
        .serial_out_o (serial_out),
        .sym_start_o  (sym_start)
    );

    // Round-robin preference: lane 0 wins alone, or on contention when lane 1
    // was the last winner.
    assign sel0 = valid0 && (!valid1 || last_q);
    assign sel1 = valid1 && !sel0;

    always_comb begin
        state_d   = state_q;
        comma_d   = comma_q;
        last_d    = last_q;
        grant0    = 1'b0;
        grant1    = 1'b0;
        sym       = FILL_SYM;
        comma_inc = (comma_q >= COMMA_TGT) ? comma_q : comma_q + 4'd1;

        unique case (state_q)
            ST_TRAIN: begin
                sym = IDLE_SYM;
                if (boundary) begin
                    // The comma being latched now counts, so ACTIVE begins
                    // right after the final training comma.
                    comma_d = comma_inc;
                    if (comma_inc == COMMA_TGT && link_en) begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!link_en) begin
                    // Drop the link at this boundary: send a comma instead of
                    // data and restart the training count.
                    sym = IDLE_SYM;
                    if (boundary) begin
                        state_d = ST_TRAIN;
                        comma_d = 4'd0;
                    end
                end else begin
                    sym    = sel0 ? data0 : (sel1 ? data1 : FILL_SYM);
                    // Reset gating keeps ready low during the reset cycle.
                    grant0 = sel0 && boundary && reset;
                    grant1 = sel1 && boundary && reset;
                    if (grant0) begin
                        last_d = 1'b0;
                    end else if (grant1) begin
                        last_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_TRAIN;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q <= ST_TRAIN;
            comma_q <= 4'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            comma_q <= comma_d;
            last_q  <= last_d;
        end
    end

    assign ready0 = grant0;
    assign ready1 = grant1;
    assign active = (state_q == ST_ACTIVE);

`ifdef TX_STATS_EN
    logic [15:0] byte_cnt0_q, byte_cnt1_q;

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            byte_cnt0_q <= 16'd0;
            byte_cnt1_q <= 16'd0;
        end else if (state_q == ST_ACTIVE) begin
            if (grant0) byte_cnt0_q <= byte_cnt0_q + 16'd1;
            if (grant1) byte_cnt1_q <= byte_cnt1_q + 16'd1;
        end
    end

    assign byte_cnt0 = byte_cnt0_q;
    assign byte_cnt1 = byte_cnt1_q;
`endif

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_serial_tx_scheduler
// Directed, table-driven bench for serial_tx_scheduler. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_serial_tx_scheduler;

    logic        clk_32f = 1'b0;
    logic        reset   = 1'b0;
    logic        link_en = 1'b0;
    logic        valid0  = 1'b0;
    logic [7:0]  data0   = 8'h00;
    logic        valid1  = 1'b0;
    logic [7:0]  data1   = 8'h00;
    logic        ready0, ready1, serial_out, active, sym_start;
`ifdef TX_STATS_EN
    logic [15:0] byte_cnt0, byte_cnt1;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int hs0 = 0;
    int hs1 = 0;

    always #5 clk_32f = ~clk_32f;

    serial_tx_scheduler #(.TRAIN_COMMAS(4)) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .link_en    (link_en),
        .valid0     (valid0),
        .data0      (data0),
        .ready0     (ready0),
        .valid1     (valid1),
        .data1      (data1),
        .ready1     (ready1),
        .serial_out (serial_out),
        .active     (active),
        .sym_start  (sym_start)
`ifdef TX_STATS_EN
        ,
        .byte_cnt0  (byte_cnt0),
        .byte_cnt1  (byte_cnt1)
`endif
    );

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic [7:0] exp_sym;
        logic       exp_r0;
        logic       exp_r1;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    // Entered on a falling edge inside a boundary cycle; leaves on the
    // falling edge of the next boundary cycle. Data is scrambled after the
    // ready cycle to prove the byte was latched.
    task automatic xfer(input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1,
                        input logic le, input int drop_at,
                        output logic [7:0] sym, output logic r0, output logic r1,
                        output logic act_first, output logic act_end,
                        output int start_err, output int mid_rdy);
        valid0 = v0; data0 = d0; valid1 = v1; data1 = d1; link_en = le;
        #1;
        r0 = ready0;
        r1 = ready1;
        sym = 8'h00; start_err = 0; mid_rdy = 0; act_first = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_32f);
            sym = {sym[6:0], serial_out};
            if (sym_start !== (i == 0)) start_err++;
            if (i == 0) act_first = active;
            data0 = ~d0;
            data1 = ~d1;
            if (i == drop_at) link_en = 1'b0;
            #1;
            if (i < 7 && (ready0 !== 1'b0 || ready1 !== 1'b0)) mid_rdy++;
        end
        act_end = active;
        $display("xfer v0=%0b v1=%0b le=%0b sym=%02h r0=%0b r1=%0b active=%0b",
                 v0, v1, le, sym, r0, r1, act_end);
    endtask

    logic [7:0] sym;
    logic       r0, r1, act_first, act_end;
    int         start_err, mid_rdy;

    task automatic train_seq(input string tag);
        for (int k = 0; k < 4; k++) begin
            xfer(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, -1, sym, r0, r1, act_first, act_end, start_err, mid_rdy);
            chk($sformatf("%s_comma%0d_sym", tag, k), {24'd0, sym}, 32'hBC);
            chk($sformatf("%s_comma%0d_start", tag, k), start_err, 0);
            chk($sformatf("%s_comma%0d_active", tag, k), {31'd0, act_end}, {31'd0, (k == 3)});
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 8'h11, 1'b1, 8'h22, 8'h11, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'h11, 1'b1, 8'h22, 8'h22, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 8'h11, 1'b1, 8'h22, 8'h11, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h11, 1'b1, 8'h22, 8'h22, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h7C, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 8'h11, 1'b1, 8'h22, 8'h11, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};

        // Reset held for three edges with a requester pending.
        reset = 1'b0; link_en = 1'b1; valid0 = 1'b1; data0 = 8'h99;
        repeat (3) @(negedge clk_32f);
        chk("rst_serial_out", {31'd0, serial_out}, 0);
        chk("rst_active",     {31'd0, active},     0);
        chk("rst_sym_start",  {31'd0, sym_start},  0);
        chk("rst_ready0",     {31'd0, ready0},     0);
        valid0 = 1'b0;
        reset  = 1'b1;

        train_seq("train");

        for (int k = 0; k < 2; k++) begin
            xfer(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, -1, sym, r0, r1, act_first, act_end, start_err, mid_rdy);
            chk($sformatf("fill%0d_sym", k), {24'd0, sym}, 32'h7C);
            chk($sformatf("fill%0d_rdy", k), {30'd0, r0, r1}, 0);
        end

        for (int i = 0; i < 12; i++) begin
            xfer(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, 1'b1, -1,
                 sym, r0, r1, act_first, act_end, start_err, mid_rdy);
            chk($sformatf("vec%0d_sym", i), {24'd0, sym}, {24'd0, vecs[i].exp_sym});
            chk($sformatf("vec%0d_ready0", i), {31'd0, r0}, {31'd0, vecs[i].exp_r0});
            chk($sformatf("vec%0d_ready1", i), {31'd0, r1}, {31'd0, vecs[i].exp_r1});
            chk($sformatf("vec%0d_start", i), start_err, 0);
            chk($sformatf("vec%0d_midready", i), mid_rdy, 0);
            chk($sformatf("vec%0d_active", i), {31'd0, act_end}, 1);
            if (vecs[i].exp_r0) hs0++;
            if (vecs[i].exp_r1) hs1++;
        end

        // link_en drops mid-symbol: the byte completes, then commas follow.
        xfer(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 3, sym, r0, r1, act_first, act_end, start_err, mid_rdy);
        chk("drop_inflight_sym", {24'd0, sym}, 32'h11);
        chk("drop_inflight_r0",  {31'd0, r0}, 1);
        chk("drop_inflight_act", {31'd0, act_end}, 1);
        hs0++;
        xfer(1'b1, 8'h44, 1'b0, 8'h00, 1'b0, -1, sym, r0, r1, act_first, act_end, start_err, mid_rdy);
        chk("drop_first_sym",    {24'd0, sym}, 32'hBC);
        chk("drop_first_r0",     {31'd0, r0}, 0);
        chk("drop_first_active", {31'd0, act_first}, 0);
        for (int k = 0; k < 5; k++) begin
            xfer(1'b1, 8'h44, 1'b0, 8'h00, 1'b0, -1, sym, r0, r1, act_first, act_end, start_err, mid_rdy);
            chk($sformatf("down%0d_sym", k), {24'd0, sym}, 32'hBC);
            chk($sformatf("down%0d_active", k), {31'd0, act_end}, 0);
        end
        xfer(1'b1, 8'h44, 1'b0, 8'h00, 1'b1, -1, sym, r0, r1, act_first, act_end, start_err, mid_rdy);
        chk("relink_sym",    {24'd0, sym}, 32'hBC);
        chk("relink_r0",     {31'd0, r0}, 0);
        chk("relink_active", {31'd0, act_end}, 1);
        xfer(1'b1, 8'h44, 1'b0, 8'h00, 1'b1, -1, sym, r0, r1, act_first, act_end, start_err, mid_rdy);
        chk("relink_data", {24'd0, sym}, 32'h44);
        hs0++;

`ifdef TX_STATS_EN
        chk("stats_cnt0", {16'd0, byte_cnt0}, hs0);
        chk("stats_cnt1", {16'd0, byte_cnt1}, hs1);
`endif

        // Reset pulsed in the middle of a data byte.
        valid0 = 1'b1; data0 = 8'hC3; link_en = 1'b1;
        #1;
        chk("midrst_pre_ready0", {31'd0, ready0}, 1);
        repeat (5) @(negedge clk_32f);
        reset = 1'b0;
        #1;
        chk("midrst_ready0_low", {31'd0, ready0}, 0);
        @(negedge clk_32f);
        chk("midrst_serial_out", {31'd0, serial_out}, 0);
        chk("midrst_sym_start",  {31'd0, sym_start},  0);
        chk("midrst_active",     {31'd0, active},     0);
        chk("midrst_ready0",     {31'd0, ready0},     0);
        hs0 = 0; hs1 = 0;
        valid0 = 1'b0;
        reset  = 1'b1;
        train_seq("retrain");
        xfer(1'b1, 8'h96, 1'b0, 8'h00, 1'b1, -1, sym, r0, r1, act_first, act_end, start_err, mid_rdy);
        chk("retrain_data", {24'd0, sym}, 32'h96);
        chk("retrain_r0",   {31'd0, r0}, 1);
        hs0++;

`ifdef TX_STATS_EN
        chk("stats_post_rst_cnt0", {16'd0, byte_cnt0}, hs0);
        chk("stats_post_rst_cnt1", {16'd0, byte_cnt1}, hs1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_tx_scheduler.md
Name: serial_tx_scheduler

Overview:
Byte-level scheduler feeding the clk_32f serial transmit path.
- After reset or link-enable, trains the link with idle commas (0xBC).
- In ACTIVE, round-robin arbitrates two byte requesters (valid/ready) and inserts 0x7C fill when neither has data.
- Serializes the chosen byte MSB-first, one bit per clk_32f, and exports link status.

Parameters:
TRAIN_COMMAS, 4, number of 0xBC symbols sent in TRAIN before entering ACTIVE (legal range 1..15)
IDLE_SYM, 8'hBC, training/idle comma
FILL_SYM, 8'h7C, fill symbol sent in ACTIVE when no requester is valid

Ports:
clk_32f  in  1  bit clock; all state changes on rising edge
reset  in  1  synchronous, active-low
link_en  in  1  permit leaving TRAIN; sampled only at byte boundaries
valid0  in  1  requester 0 has a byte
data0  in  8  requester 0 byte
ready0  out  1  combinational; byte 0 accepted this cycle
valid1  in  1  requester 1 has a byte
data1  in  8  requester 1 byte
ready1  out  1  combinational; byte 1 accepted this cycle
serial_out  out  1  registered serial bit
active  out  1  registered; 1 while state is ACTIVE
sym_start  out  1  registered; 1 in the cycle serial_out carries bit 7 of a symbol

Behaviour:
- Reset (reset==0 at an edge):
  - serial_out=0, active=0, sym_start=0.
  - bit counter cnt=0, comma counter=0, state=TRAIN, last_grant=1 (so lane 0 wins first).
  - ready0/ready1 forced 0 while reset==0.
- Byte boundary is any cycle with cnt==0. cnt increments every edge and wraps 7->0.
- At a boundary, the symbol sym is chosen combinationally:
  - TRAIN: sym=IDLE_SYM.
  - ACTIVE, valid0 only: grant 0.
  - ACTIVE, valid1 only: grant 1.
  - ACTIVE, both valid: grant the lane != last_grant.
  - ACTIVE, none valid: sym=FILL_SYM, no grant.
- On a grant, readyN=1 for that single cycle. sym=dataN, and last_grant updates at the edge.
- readyN is 0 whenever cnt!=0. validN may fall without a handshake. data must be stable only during the ready cycle.
- Serialization: sym is latched into an 8-bit shift register at the boundary edge.
  - serial_out = sym[7] after the boundary edge, then sym[6..0] on the next 7 edges.
  - sym_start=1 coincident with sym[7].
  - Latency from the ready cycle to the first bit is 1 edge. Symbol period is exactly 8 clk_32f.
- State machine, evaluated at boundaries only:
  - TRAIN: each IDLE_SYM sent increments the comma counter.
  - TRAIN->ACTIVE when the comma counter reaches TRAIN_COMMAS and link_en==1; the comma counter saturates.
  - ACTIVE->TRAIN when link_en==0; the comma counter is cleared.
  - `active` updates at the same edge as the state.
- link_en changes mid-symbol have no effect until the next boundary. A symbol in flight always completes.
- Reset mid-symbol aborts it immediately. serial_out=0 on the next edge. No ready is issued in that cycle.

Optional Feature:
TX_STATS_EN:
- Defined: adds outputs byte_cnt0[15:0] and byte_cnt1[15:0].
  - Each increments on its lane's ready handshake and wraps 0xFFFF->0.
  - Both cleared by reset and frozen in TRAIN.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package serial_link_pkg:
  - IDLE_SYM/FILL_SYM constants.
  - State encoding TRAIN=1'b0, ACTIVE=1'b1.
  - Symbol width 8.
- Sub-module tx_byte_shifter: owns cnt, the shift register, serial_out and sym_start; outputs boundary (cnt==0).
- The scheduler holds the FSM, arbiter and counters.

Test Plan:
- Reset held 3 edges, then released with link_en=1 and no valids -> serial_out stream 10111100 x4 with sym_start every 8th cycle, then active=1 and 01111100 repeating.
- ACTIVE, valid0=1 data0=0xA5, valid1=0 -> ready0 single-cycle pulse at a boundary; next 8 bits 10100101; ready1 never asserted.
- ACTIVE, both valid continuously (data0=0x11, data1=0x22) -> grants alternate 0,1,0,1 starting with lane 0; stream 0x11,0x22,0x11,0x22.
- link_en dropped at bit 3 of 0x11 -> 0x11 completes; next symbol 0xBC; active=0 at that boundary; 4 commas required before ACTIVE returns.
- reset pulsed low at bit 5 of a data byte -> serial_out=0, ready=0, cnt restarts; 0xBC training resumes from comma 0.
- With TX_STATS_EN, 70000 lane-0 handshakes -> byte_cnt0 = 70000 mod 65536 = 4464; byte_cnt1=0.
